// File: rtl/keypad_pkg.sv
// Shared types and key mapping for the 4x4 keypad entry path.
// The mapping table is the single place that ties a row/column position to a key code.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Rows are active-low; when several are low, the lowest index wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] row;
    if (!rows[0])      row = 2'd0;
    else if (!rows[1]) row = 2'd1;
    else if (!rows[2]) row = 2'd2;
    else               row = 2'd3;
    return row;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running modulo counter producing a one-cycle enable every CNTMAX+1 clocks.
// Also usable as the refresh enable for the display path.
module scan_tick_gen #(
  parameter int CNTMAX = 49999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CNTMAX > 0) ? $clog2(CNTMAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNTMAX);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Scans a 4x4 keypad, debounces presses and releases, and assembles a two-digit
// BCD preset; '#' issues a one-cycle preset strobe, '*' clears the entry.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_CNTMAX    = 49999,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       preset,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_TICKS - 1);

  logic           w_tick;
  logic [3:0]     r_row_meta;
  logic [3:0]     r_row_sync;
  state_e         r_state;
  logic [1:0]     r_col;
  logic [3:0]     r_row_lat;
  logic [DBW-1:0] r_db_cnt;
  logic [3:0]     r_units;
  logic [3:0]     r_tens;
  logic [3:0]     r_code;
  logic           r_preset;
  logic           r_valid;

  logic           w_any_low;
  logic           w_same;
  logic           w_db_done;
  logic           w_accept;
  logic [3:0]     w_code;

  scan_tick_gen #(
    .CNTMAX(SCAN_CNTMAX)
  ) u_scan_tick (
    .clk (clk_50M),
    .rst (rst),
    .tick(w_tick)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= key_row;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_any_low = (r_row_sync != 4'hF);
  assign w_same    = (r_row_sync == r_row_lat);
  assign w_db_done = (r_db_cnt == DB_LAST);
  assign w_accept  = w_tick && (r_state == ST_DEBOUNCE) && w_same && w_db_done;
  // The column is frozen outside SCAN, so r_col is the latched column here.
  assign w_code    = key_map(lowest_low_row(r_row_lat), r_col);
  assign key_col   = ~(4'b0001 << r_col);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_col     <= 2'd0;
      r_row_lat <= 4'hF;
      r_db_cnt  <= '0;
    end else if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_any_low) begin
            r_row_lat <= r_row_sync;
            r_db_cnt  <= '0;
            r_state   <= ST_DEBOUNCE;
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_same) begin
            r_state <= ST_SCAN;
            r_col   <= r_col + 2'd1;
          end else if (w_db_done) begin
            r_db_cnt <= '0;
            r_state  <= ST_HELD;
          end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
          end
        end
        ST_HELD: begin
          if (w_any_low) begin
            r_db_cnt <= '0;
          end else if (w_db_done) begin
            r_db_cnt <= '0;
            r_state  <= ST_SCAN;
            r_col    <= r_col + 2'd1;
          end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_units  <= 4'd0;
      r_tens   <= 4'd0;
      r_code   <= 4'd0;
      r_preset <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_preset <= 1'b0;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_code  <= w_code;
        if (w_code <= 4'd9) begin
          r_tens  <= r_units;
          r_units <= w_code;
        end else if (w_code == KEY_STAR) begin
          r_tens  <= 4'd0;
          r_units <= 4'd0;
        end else if (w_code == KEY_HASH) begin
          r_preset <= 1'b1;
        end
      end
    end
  end

  assign units     = r_units;
  assign tens      = r_tens;
  assign key_code  = r_code;
  assign preset    = r_preset;
  assign key_valid = r_valid;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry: a keypad model drives rows from the column drive,
// a reference model queues expected accepts, and a monitor checks every key_valid.
module tb_keypad_bcd_entry;

  localparam int SCAN_CNTMAX    = 3;
  localparam int DEBOUNCE_TICKS = 2;
  localparam int TICK_CYC       = SCAN_CNTMAX + 1;

  logic       clk_50M = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] units;
  logic [3:0] tens;
  logic       preset;
  logic       key_valid;
  logic [3:0] key_code;

  logic [3:0] press_rows = 4'h0;
  logic [1:0] press_col  = 2'd0;

  int checks   = 0;
  int failures = 0;
  int kv_count = 0;

  logic [3:0]  keytab [16];
  logic [3:0]  m_units = 4'd0;
  logic [3:0]  m_tens  = 4'd0;
  logic [12:0] exp_q[$];

  keypad_bcd_entry #(
    .SCAN_CNTMAX   (SCAN_CNTMAX),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .units    (units),
    .tens     (tens),
    .preset   (preset),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  // clock / watchdog
  always #5 clk_50M = ~clk_50M;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Keypad model: a pressed switch connects its row to its column.
  always_comb begin
    key_row = 4'hF;
    if (key_col[press_col] == 1'b0) key_row = ~press_rows;
  end

  // Monitor / scoreboard
  always @(negedge clk_50M) begin
    if (key_valid) begin
      logic [12:0] got;
      logic [12:0] exp;
      kv_count++;
      checks++;
      got = {preset, key_code, tens, units};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_key_valid got preset=%b code=%h tens=%0d units=%0d",
                 preset, key_code, tens, units);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL accept got preset=%b code=%h tens=%0d units=%0d exp preset=%b code=%h tens=%0d units=%0d",
                   got[12], got[11:8], got[7:4], got[3:0], exp[12], exp[11:8], exp[7:4], exp[3:0]);
        end
      end
    end else if (preset) begin
      checks++;
      failures++;
      $display("FAIL preset_without_key_valid got preset=1 exp preset=0");
    end
  end

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check4({tag, "_key_col"}, key_col, 4'b1110);
    check4({tag, "_units"}, units, 4'd0);
    check4({tag, "_tens"}, tens, 4'd0);
    check4({tag, "_key_code"}, key_code, 4'd0);
    check4({tag, "_key_valid"}, {3'b0, key_valid}, 4'd0);
    check4({tag, "_preset"}, {3'b0, preset}, 4'd0);
  endtask

  // Reference model: digits shift in, '*' clears, '#' strobes preset.
  task automatic expect_key(input logic [3:0] rows, input logic [1:0] col);
    logic [3:0] code;
    logic       pre;
    int         r;
    r = 3;
    for (int i = 3; i >= 0; i--) if (rows[i]) r = i;
    code = keytab[r * 4 + int'(col)];
    pre  = 1'b0;
    if (code <= 4'd9) begin
      m_tens  = m_units;
      m_units = code;
    end else if (code == 4'hE) begin
      m_tens  = 4'd0;
      m_units = 4'd0;
    end else if (code == 4'hF) begin
      pre = 1'b1;
    end
    exp_q.push_back({pre, code, m_tens, m_units});
  endtask

  task automatic press(input logic [3:0] rows, input logic [1:0] col,
                       input int hold_ticks, input int rel_ticks);
    int n;
    expect_key(rows, col);
    press_col  = col;
    press_rows = rows;
    repeat (hold_ticks * TICK_CYC) @(negedge clk_50M);
    press_rows = 4'h0;
    repeat (rel_ticks * TICK_CYC) @(negedge clk_50M);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk_50M);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL key_accept_timeout got pending=%0d exp pending=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Returns at the first negedge where column col has just become driven.
  task automatic wait_col_start(input logic [1:0] col, output bit ok);
    logic [3:0] tgt;
    logic [3:0] prev;
    tgt  = ~(4'b0001 << col);
    prev = key_col;
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_50M);
      if (key_col == tgt && prev != tgt) begin
        ok = 1'b1;
        return;
      end
      prev = key_col;
    end
    checks++;
    failures++;
    $display("FAIL wait_col_start timeout col=%0d got key_col=%b exp key_col=%b", col, key_col, tgt);
  endtask

  initial begin
    logic [3:0] prev_col;
    int         last_change;
    int         n_changes;
    int         kv_before;
    bit         ok;

    keytab = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'hE, 4'h0, 4'hF, 4'hD};

    // clock / reset
    rst = 1'b1;
    repeat (3) @(negedge clk_50M);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle scan: rotate one column per tick period.
    prev_col    = key_col;
    last_change = -1;
    n_changes   = 0;
    for (int cyc = 0; cyc < 40 && n_changes < 5; cyc++) begin
      @(negedge clk_50M);
      if (key_col != prev_col) begin
        check4("scan_rotation", key_col, {prev_col[2:0], prev_col[3]});
        if (last_change >= 0) check4("scan_period", 4'(cyc - last_change), 4'(TICK_CYC));
        last_change = cyc;
        prev_col    = key_col;
        n_changes++;
      end
    end
    check4("scan_changes_seen", 4'(n_changes), 4'd5);

    // Key 5, then 4 2 #
    press(4'b0010, 2'd1, 20, 6);
    press(4'b0010, 2'd0, 20, 6);
    press(4'b0001, 2'd1, 20, 6);
    press(4'b1000, 2'd2, 20, 6);

    // Reset while key 9 is in debounce: nothing may be accepted.
    kv_before = kv_count;
    wait_col_start(2'd2, ok);
    press_col  = 2'd2;
    press_rows = 4'b0100;
    repeat (5) @(negedge clk_50M);
    rst        = 1'b1;
    press_rows = 4'h0;
    @(negedge clk_50M);
    check_reset_outputs("mid_reset");
    rst     = 1'b0;
    m_units = 4'd0;
    m_tens  = 4'd0;
    repeat (10 * TICK_CYC) @(negedge clk_50M);
    check4("no_accept_after_reset", 4'(kv_count - kv_before), 4'd0);

    // 4 2 then '*'
    press(4'b0010, 2'd0, 20, 6);
    press(4'b0001, 2'd1, 20, 6);
    press(4'b1000, 2'd0, 20, 6);

    // Bounce on key 8: one tick low, then released.
    kv_before = kv_count;
    wait_col_start(2'd1, ok);
    press_col  = 2'd1;
    press_rows = 4'b0100;
    repeat (TICK_CYC) @(negedge clk_50M);
    press_rows = 4'h0;
    prev_col   = key_col;
    for (int i = 0; i < 3 * TICK_CYC; i++) begin
      @(negedge clk_50M);
      if (key_col != prev_col) break;
    end
    check4("bounce_resume_col", key_col, 4'b1011);
    repeat (8 * TICK_CYC) @(negedge clk_50M);
    check4("bounce_no_accept", 4'(kv_count - kv_before), 4'd0);

    // Long hold of 7 yields a single accept.
    kv_before = kv_count;
    press(4'b0100, 2'd0, 50, 6);
    check4("hold_single_accept", 4'(kv_count - kv_before), 4'd1);

    // Two rows in one column: lowest row wins (4 over 7).
    press(4'b0110, 2'd0, 20, 6);

    // Random keys, sometimes with extra rows in the same column.
    for (int k = 0; k < 30; k++) begin
      logic [3:0] rows;
      rows = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) rows = rows | 4'($urandom_range(0, 15));
      press(rows, 2'($urandom_range(0, 3)), $urandom_range(12, 30), $urandom_range(4, 8));
    end

    repeat (4) @(negedge clk_50M);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
